mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control unit for the multi-cycle MIPS core. It sequences the shared datapath (one ALU, one unified instruction/data memory, one register file) across several cycles per instruction, and drives every datapath enable and mux select. It replaces the single-cycle combinational decoder. It also stalls on a memory-ready handshake.

## Interface
Parameters:
- none. All encodings come from the shared package.

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- op  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-back select: 1 = memory data
- regdst  out  1  destination register: 1 = rd, 0 = rt
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign/zero-extended immediate, 11 = immediate << 2
- imm_zext  out  1  zero-extend the immediate (ORI only)
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Supported instructions: R-type (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, slti 001010, j 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, IMMEX, IMMWB, JEX.
- FETCH:
  - Drives iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - If mem_ready: irwrite=1, pcen=1, go to DECODE. Otherwise stay in FETCH with both enables low.
- DECODE: alusrca=0, alusrcb=11, add (precomputes the branch target). Next state:
  - lw or sw → MEMADR
  - R-type → RTYPEEX
  - beq → BEQEX
  - addi, ori or slti → IMMEX
  - j → JEX
  - any other opcode → FETCH, with illegal_op=1
- MEMADR: alusrca=1, alusrcb=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. If mem_ready → MEMWB, else hold.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 → FETCH.
- MEMWR: iord=1, memwrite=1 while in this state. If mem_ready: instr_done=1 → FETCH, else hold.
- RTYPEEX: alusrca=1, alusrcb=00; alucontrol decoded from funct → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1 → FETCH.
  - An unknown funct decodes to alucontrol=010, and regwrite is still asserted.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero, instr_done=1 → FETCH.
- IMMEX: alusrca=1, alusrcb=10. Operation by opcode:
  - addi → 010
  - ori → 001 with imm_zext=1
  - slti → 111
  - then → IMMWB
- IMMWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 → FETCH.
- JEX: pcsrc=10, pcen=1, instr_done=1 → FETCH.
- Defaults: every output not listed for a state is 0.

## Timing
- Reset:
  - State is FETCH on the first edge with reset=1.
  - While reset=1, pcen, irwrite, memwrite, regwrite, instr_done and illegal_op are forced to 0.
  - After reset releases, FETCH proceeds normally.
- Reset during an instruction abandons it at the next edge. No write enable is asserted in the reset cycle.
- Latency, in cycles, with no stalls:
  - R-type, sw, addi, ori, slti: 4
  - lw: 5
  - beq, j: 3
  - Each cycle in which mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Output timing: outputs are Moore decodes of the state register, except:
  - pcen and irwrite in FETCH depend on mem_ready
  - pcen in BEQEX depends on zero
  - instr_done in MEMWR depends on mem_ready
- op and funct must be stable from DECODE until FETCH. They come from the IR, which loads only in FETCH.

## Structure
- Shared package mips_pkg holds:
  - the opcode and funct localparams
  - the 4-bit state encoding: FETCH=0 through JEX=11
  - the alucontrol codes
  - the alusrcb and pcsrc codes
- Sub-module mips_alu_dec: combinational mapping of (state class, op, funct) to alucontrol. The FSM (state register plus output decode) stays in mips_multicycle_ctrl.

## Test plan
- Reset, then op=000000, funct=100000, mem_ready=1 → states FETCH, DECODE, RTYPEEX, ALUWB. ALUWB drives regwrite=1, regdst=1, alucontrol=010. instr_done pulses in cycle 4.
- lw (op=100011), with mem_ready=0 for 2 cycles in MEMRD → 7 cycles total. In MEMWB: memtoreg=1, regwrite=1. iord=1 throughout MEMRD.
- beq (op=000100):
  - with zero=1 → pcen=1, pcsrc=01, alucontrol=110 in cycle 3
  - repeated with zero=0 → pcen stays 0
- Immediates, checked in IMMEX:
  - ori (op=001101) → alucontrol=001, imm_zext=1
  - slti (op=001010) → alucontrol=111
  - addi (op=001000) → alucontrol=010
- sw stalled in MEMWR by mem_ready=0 for 3 cycles → memwrite=1 held for 4 cycles, then FETCH. regwrite is never asserted.
- Boundary cases:
  - op=111111 → illegal_op pulses in DECODE, then FETCH
  - reset=1 asserted in MEMADR → next state FETCH, with no memwrite or regwrite asserted

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct codes,
// FSM state encoding, ALU operation codes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Which source the ALU decoder should use to pick the operation.
    typedef enum logic [2:0] {
        ALU_CLS_NONE  = 3'd0,
        ALU_CLS_ADD   = 3'd1,
        ALU_CLS_SUB   = 3'd2,
        ALU_CLS_FUNCT = 3'd3,
        ALU_CLS_IMM   = 3'd4
    } alu_cls_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ORI, OP_SLTI, OP_J: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: maps the FSM's operation class plus op/funct to the
// 3-bit alucontrol code.
module mips_alu_dec
    import mips_pkg::*;
(
    input  alu_cls_t    i_cls,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucontrol
);

    // Operation select; unknown funct/op fall back to add.
    always_comb begin
        o_alucontrol = 3'b000;
        case (i_cls)
            ALU_CLS_NONE: o_alucontrol = 3'b000;
            ALU_CLS_ADD:  o_alucontrol = ALU_ADD;
            ALU_CLS_SUB:  o_alucontrol = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_alucontrol = ALU_ADD;
                    FUNCT_SUB: o_alucontrol = ALU_SUB;
                    FUNCT_AND: o_alucontrol = ALU_AND;
                    FUNCT_OR:  o_alucontrol = ALU_OR;
                    FUNCT_SLT: o_alucontrol = ALU_SLT;
                    default:   o_alucontrol = ALU_ADD;
                endcase
            end
            ALU_CLS_IMM: begin
                case (i_op)
                    OP_ADDI: o_alucontrol = ALU_ADD;
                    OP_ORI:  o_alucontrol = ALU_OR;
                    OP_SLTI: o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/write-back
// over a shared datapath and stalls on the memory-ready handshake.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcen,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic        imm_zext,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        instr_done,
    output logic        illegal_op
);

    state_t     r_state;
    state_t     w_next_state;
    alu_cls_t   w_alu_cls;
    logic       w_pcen;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_instr_done;
    logic       w_illegal_op;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) w_next_state = S_DECODE;
                else           w_next_state = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:              w_next_state = S_MEMADR;
                    OP_RTYPE:                  w_next_state = S_RTYPEEX;
                    OP_BEQ:                    w_next_state = S_BEQEX;
                    OP_ADDI, OP_ORI, OP_SLTI:  w_next_state = S_IMMEX;
                    OP_J:                      w_next_state = S_JEX;
                    default:                   w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      w_next_state = S_MEMRD;
                else if (op == OP_SW) w_next_state = S_MEMWR;
                else                  w_next_state = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready) w_next_state = S_MEMWB;
                else           w_next_state = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) w_next_state = S_FETCH;
                else           w_next_state = S_MEMWR;
            end
            S_RTYPEEX: w_next_state = S_ALUWB;
            S_IMMEX:   w_next_state = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BEQEX, S_IMMWB, S_JEX: w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Output decode; anything not driven by a state stays 0.
    always_comb begin
        w_pcen       = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = ALUSRCB_B;
        imm_zext     = 1'b0;
        pcsrc        = PCSRC_ALU;
        w_alu_cls    = ALU_CLS_NONE;
        case (r_state)
            S_FETCH: begin
                alusrcb   = ALUSRCB_FOUR;
                w_alu_cls = ALU_CLS_ADD;
                w_pcen    = mem_ready;
                w_irwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb      = ALUSRCB_IMMSH;
                w_alu_cls    = ALU_CLS_ADD;
                w_illegal_op = ~op_supported(op);
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = ALUSRCB_IMM;
                w_alu_cls = ALU_CLS_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                w_memwrite   = 1'b1;
                w_instr_done = mem_ready;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                w_alu_cls = ALU_CLS_FUNCT;
            end
            S_ALUWB: begin
                // Keep the funct operation on the ALU through write-back.
                regdst       = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
                w_alu_cls    = ALU_CLS_FUNCT;
            end
            S_BEQEX: begin
                alusrca      = 1'b1;
                w_alu_cls    = ALU_CLS_SUB;
                pcsrc        = PCSRC_ALUOUT;
                w_pcen       = zero;
                w_instr_done = 1'b1;
            end
            S_IMMEX: begin
                alusrca   = 1'b1;
                alusrcb   = ALUSRCB_IMM;
                w_alu_cls = ALU_CLS_IMM;
                imm_zext  = (op == OP_ORI);
            end
            S_IMMWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JEX: begin
                pcsrc        = PCSRC_JUMP;
                w_pcen       = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                w_alu_cls = ALU_CLS_NONE;
            end
        endcase
    end

    mips_alu_dec u_alu_dec (
        .i_cls        (w_alu_cls),
        .i_op         (op),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );

    // No state-changing strobe may leave the controller while reset is held.
    assign pcen       = w_pcen       & ~reset;
    assign irwrite    = w_irwrite    & ~reset;
    assign memwrite   = w_memwrite   & ~reset;
    assign regwrite   = w_regwrite   & ~reset;
    assign instr_done = w_instr_done & ~reset;
    assign illegal_op = w_illegal_op & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl: per-cycle vectors of
// inputs and hand-computed outputs, plus a stalled-fetch latency sequence.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       imm_zext;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       illegal_op;
    } exp_t;

    typedef struct {
        logic [63:0] name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        z;
        logic        rdy;
        exp_t        e;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    exp_t       got;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (got.pcen),
        .irwrite    (got.irwrite),
        .memwrite   (got.memwrite),
        .regwrite   (got.regwrite),
        .iord       (got.iord),
        .memtoreg   (got.memtoreg),
        .regdst     (got.regdst),
        .alusrca    (got.alusrca),
        .alusrcb    (got.alusrcb),
        .imm_zext   (got.imm_zext),
        .pcsrc      (got.pcsrc),
        .alucontrol (got.alucontrol),
        .instr_done (got.instr_done),
        .illegal_op (got.illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Args: pcen irw memw regw iord m2r rdst asa asb zext pcsrc alu done ill
    function automatic exp_t mk(input logic pe, input logic irw, input logic mw,
                                input logic rw, input logic io, input logic m2r,
                                input logic rd, input logic asa, input logic [1:0] asb,
                                input logic zx, input logic [1:0] pcs,
                                input logic [2:0] alu, input logic dn, input logic il);
        exp_t e;
        e = '{pe, irw, mw, rw, io, m2r, rd, asa, asb, zx, pcs, alu, dn, il};
        return e;
    endfunction

    task automatic add(input logic [63:0] nm, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic rdy, input exp_t e);
        vec_t v;
        v.name = nm; v.rst = rst; v.op = o; v.funct = f; v.z = z; v.rdy = rdy; v.e = e;
        vecs.push_back(v);
    endtask

    exp_t E_FETCH, E_FSTALL, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_MEMWR_D;
    exp_t E_IMMWB, E_JEX;

    initial begin
        int fetch_cycles;
        int done_cycle;
        E_FETCH   = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,3'b010,1'b0,1'b0);
        E_FSTALL  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,3'b010,1'b0,1'b0);
        E_DEC     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,3'b010,1'b0,1'b0);
        E_MEMADR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b010,1'b0,1'b0);
        E_MEMRD   = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0);
        E_MEMWB   = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0);
        E_MEMWR   = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0);
        E_MEMWR_D = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0);
        E_IMMWB   = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0);
        E_JEX     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,3'b000,1'b1,1'b0);

        // reset held in FETCH with memory ready: enables must stay low
        add("reset", 1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1, E_FSTALL);
        // add
        add("add_f",  1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, E_FETCH);
        add("add_d",  1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, E_DEC);
        add("add_ex", 1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0));
        add("add_wb", 1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b0));
        // sub, and, or, slt execute-cycle operations
        add("sub_f",  1'b0, 6'b000000, 6'b100010, 1'b0, 1'b1, E_FETCH);
        add("sub_d",  1'b0, 6'b000000, 6'b100010, 1'b0, 1'b1, E_DEC);
        add("sub_ex", 1'b0, 6'b000000, 6'b100010, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b110,1'b0,1'b0));
        add("sub_wb", 1'b0, 6'b000000, 6'b100010, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b110,1'b1,1'b0));
        add("and_f",  1'b0, 6'b000000, 6'b100100, 1'b0, 1'b1, E_FETCH);
        add("and_d",  1'b0, 6'b000000, 6'b100100, 1'b0, 1'b1, E_DEC);
        add("and_ex", 1'b0, 6'b000000, 6'b100100, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0));
        add("and_wb", 1'b0, 6'b000000, 6'b100100, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0));
        add("or_f",   1'b0, 6'b000000, 6'b100101, 1'b0, 1'b1, E_FETCH);
        add("or_d",   1'b0, 6'b000000, 6'b100101, 1'b0, 1'b1, E_DEC);
        add("or_ex",  1'b0, 6'b000000, 6'b100101, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b001,1'b0,1'b0));
        add("or_wb",  1'b0, 6'b000000, 6'b100101, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b001,1'b1,1'b0));
        add("slt_f",  1'b0, 6'b000000, 6'b101010, 1'b0, 1'b1, E_FETCH);
        add("slt_d",  1'b0, 6'b000000, 6'b101010, 1'b0, 1'b1, E_DEC);
        add("slt_ex", 1'b0, 6'b000000, 6'b101010, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b111,1'b0,1'b0));
        add("slt_wb", 1'b0, 6'b000000, 6'b101010, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b111,1'b1,1'b0));
        // unknown funct: add, still writes back
        add("unk_f",  1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, E_FETCH);
        add("unk_d",  1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, E_DEC);
        add("unk_ex", 1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0));
        add("unk_wb", 1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b0));
        // lw with two stall cycles in MEMRD: 7 cycles
        add("lw_f",   1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("lw_d",   1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("lw_adr", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMADR);
        add("lw_rd0", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMRD);
        add("lw_rd1", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMRD);
        add("lw_rd2", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMRD);
        add("lw_wb",  1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMWB);
        // beq taken / not taken
        add("beq1_f", 1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, E_FETCH);
        add("beq1_d", 1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, E_DEC);
        add("beq1_x", 1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1,
            mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b110,1'b1,1'b0));
        add("beq0_f", 1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("beq0_d", 1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("beq0_x", 1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,3'b110,1'b1,1'b0));
        // immediates
        add("ori_f",  1'b0, 6'b001101, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("ori_d",  1'b0, 6'b001101, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("ori_ex", 1'b0, 6'b001101, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,3'b001,1'b0,1'b0));
        add("ori_wb", 1'b0, 6'b001101, 6'b000000, 1'b0, 1'b1, E_IMMWB);
        add("slti_f", 1'b0, 6'b001010, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("slti_d", 1'b0, 6'b001010, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("slti_x", 1'b0, 6'b001010, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b111,1'b0,1'b0));
        add("slti_w", 1'b0, 6'b001010, 6'b000000, 1'b0, 1'b1, E_IMMWB);
        add("addi_f", 1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("addi_d", 1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("addi_x", 1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b010,1'b0,1'b0));
        add("addi_w", 1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1, E_IMMWB);
        // sw stalled 3 cycles in MEMWR: memwrite held 4 cycles
        add("sw_f",   1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("sw_d",   1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("sw_adr", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_MEMADR);
        add("sw_wr0", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, E_MEMWR);
        add("sw_wr1", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, E_MEMWR);
        add("sw_wr2", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, E_MEMWR);
        add("sw_wr3", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_MEMWR_D);
        // jump
        add("j_f",    1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("j_d",    1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("j_x",    1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, E_JEX);
        // illegal opcode
        add("ill_f",  1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("ill_d",  1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,3'b010,1'b0,1'b1));
        add("ill_bk", 1'b0, 6'b111111, 6'b000000, 1'b0, 1'b0, E_FSTALL);
        // reset in MEMADR of a sw abandons it
        add("rsa_f",  1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("rsa_d",  1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("rsa_ad", 1'b1, 6'b101011, 6'b000000, 1'b0, 1'b1, E_MEMADR);
        add("rsa_bk", 1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, E_FSTALL);
        // reset during lw write-back: regwrite and instr_done suppressed
        add("rsw_f",  1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("rsw_d",  1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("rsw_ad", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMADR);
        add("rsw_rd", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMRD);
        add("rsw_wb", 1'b1, 6'b100011, 6'b000000, 1'b0, 1'b1,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0));
        add("rsw_bk", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_FETCH);
        add("rsw_d2", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_DEC);
        add("rsw_a2", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMADR);
        add("rsw_r2", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMRD);
        add("rsw_w2", 1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMWB);

        reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].z; mem_ready = vecs[i].rdy;
            #1;
            n_checks++;
            if (got !== vecs[i].e) begin
                n_fail++;
                $display("FAIL %0s: got %b required %b", vecs[i].name, got, vecs[i].e);
            end
        end

        // Hand sequence: j with FETCH stalled 2 cycles completes in cycle 5.
        done_cycle = 0;
        fetch_cycles = 0;
        for (int c = 1; c <= 20 && done_cycle == 0; c++) begin
            @(negedge clk);
            reset = 1'b0; op = 6'b000010; zero = 1'b0;
            mem_ready = (c > 2) ? 1'b1 : 1'b0;
            #1;
            if (got.alusrcb == 2'b01) fetch_cycles++;
            if (got.instr_done) done_cycle = c;
        end
        n_checks++;
        if (done_cycle != 5) begin
            n_fail++;
            $display("FAIL j_stall_latency: got cycle %0d required 5", done_cycle);
        end
        n_checks++;
        if (fetch_cycles != 3) begin
            n_fail++;
            $display("FAIL j_stall_fetch: got %0d fetch cycles required 3", fetch_cycles);
        end

        // Hand sequence: back in FETCH after the jump.
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (got !== E_FETCH) begin
            n_fail++;
            $display("FAIL j_return_fetch: got %b required %b", got, E_FETCH);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
